lcd_spi_sequencer: RTL and testbench

Memory-mapped command queue that sequences the byte-level `spi_controller` for the LCD. The CPU posts command bytes, data bytes and delay tokens over the icicle memory bus. The block drains them in order, drives the `spi_start`/`spi_dc`/data handshake into the SPI engine, and times inter-command delays, so firmware never polls `spi_busy` per byte. It sits on the bus beside `uart`/`timer`, decoded by its own `sel_in`, and owns the `spi_controller` processor-side port.

---
 rtl/lcd_seq_pkg.sv | 36 +++
 rtl/lcd_spi_sequencer_sync_fifo.sv | 61 ++++++
 rtl/lcd_spi_sequencer.sv | 159 +++++++++++++++
 tb/tb_lcd_spi_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// lcd_seq_pkg : shared types and register map for the LCD SPI sequencer
// Revision    : 1.0
// ============================================================================
package lcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DELAY = 2'd3
    } lcd_seq_state_t;

    // byte_val carries the command/data byte, or the tick count for delays
    typedef struct packed {
        logic       delay;
        logic       dc;
        logic [7:0] byte_val;
    } lcd_seq_entry_t;

    localparam int ENTRY_W = 10;

    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_DELAY  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_LEVEL_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/lcd_spi_sequencer_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO, power-of-two depth, no overflow tracking
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_sequencer.sv
`default_nettype none
// ============================================================================
// lcd_spi_sequencer : bus-mapped command/data/delay queue feeding the SPI engine
// Revision          : 1.0
// ============================================================================
module lcd_spi_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int TICK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        spi_start,
    output logic [7:0]  spi_data_out,
    output logic        spi_dc,
    input  logic        spi_busy,
    input  logic        spi_done
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_CYCLES - 1);

    lcd_seq_state_t state_q, state_d;
    logic [7:0]     data_q, data_d;
    logic           dc_q, dc_d;
    logic [7:0]     tick_q, tick_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           ovf_q, ovf_d;

    logic [1:0]     w_reg;
    logic           w_wr;
    logic           w_enq;
    logic           w_ovf_clr;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [LW-1:0]  w_level;
    lcd_seq_entry_t w_new;
    lcd_seq_entry_t w_head;
    logic [31:0]    w_status;
    logic           w_unused_bits;

    assign w_reg     = address_in[3:2];
    assign w_wr      = sel_in && (write_mask_in != 4'd0);
    assign w_enq     = w_wr && (w_reg != REG_STATUS);
    assign w_ovf_clr = w_wr && (w_reg == REG_STATUS) && write_value_in[STAT_OVF];

    assign w_new.delay    = (w_reg == REG_DELAY);
    assign w_new.dc       = (w_reg == REG_DATA);
    assign w_new.byte_val = write_value_in[7:0];

    assign w_unused_bits = ^{read_in, address_in[31:4], address_in[1:0], write_value_in[31:8]};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_enq),
        .wdata_i (w_new),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dc_d    = dc_q;
        tick_d  = tick_q;
        presc_d = presc_q;
        w_pop   = 1'b0;
        // Fullness is sampled before any same-cycle pop; set beats clear
        ovf_d   = ovf_q;
        if (w_enq && w_full) begin
            ovf_d = 1'b1;
        end else if (w_ovf_clr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!w_empty && !spi_busy) begin
                    w_pop = 1'b1;
                    if (!w_head.delay) begin
                        data_d  = w_head.byte_val;
                        dc_d    = w_head.dc;
                        state_d = ST_START;
                    end else if (w_head.byte_val != 8'd0) begin
                        tick_d  = w_head.byte_val;
                        presc_d = PRESC_RELOAD;
                        state_d = ST_DELAY;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (spi_done) state_d = ST_IDLE;
            end
            ST_DELAY: begin
                if (presc_q == '0) begin
                    presc_d = PRESC_RELOAD;
                    tick_d  = tick_q - 1'b1;
                    if (tick_q == 8'd1) state_d = ST_IDLE;
                end else begin
                    presc_d = presc_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dc_q    <= 1'b0;
            tick_q  <= '0;
            presc_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            tick_q  <= tick_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        w_status                           = '0;
        w_status[STAT_BUSY]                = !w_empty || (state_q != ST_IDLE);
        w_status[STAT_FULL]                = w_full;
        w_status[STAT_EMPTY]               = w_empty;
        w_status[STAT_OVF]                 = ovf_q;
        w_status[STAT_LEVEL_LSB +: 8]      = 8'(w_level);
    end

    assign read_value_out = (sel_in && (w_reg == REG_STATUS)) ? w_status : 32'd0;
    assign ready_out      = sel_in;
    assign spi_start      = (state_q == ST_START);
    assign spi_data_out   = data_q;
    assign spi_dc         = dc_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lcd_spi_sequencer : directed + random bench with a queue-based reference
// Revision             : 1.0
// ============================================================================
module tb_lcd_spi_sequencer;

    localparam int DEPTH = 4;
    localparam int TICK  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic [3:0]  wmask = '0;
    logic [31:0] wv = '0;
    logic [31:0] read_value_out;
    logic        ready_out;
    logic        spi_start;
    logic [7:0]  spi_data_out;
    logic        spi_dc;
    wire         spi_busy;
    wire         spi_done;

    int   cyc = 0;
    int   eng_cnt = 0;
    logic eng_done = 1'b0;
    logic hold = 1'b0;
    logic inj_done = 1'b0;
    int   fix_len = 0;

    int   n_cmp = 0;
    int   n_bad = 0;

    lcd_spi_sequencer #(
        .DEPTH       (DEPTH),
        .TICK_CYCLES (TICK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address_in     (addr),
        .sel_in         (sel),
        .read_in        (rd),
        .read_value_out (read_value_out),
        .write_mask_in  (wmask),
        .write_value_in (wv),
        .ready_out      (ready_out),
        .spi_start      (spi_start),
        .spi_data_out   (spi_data_out),
        .spi_dc         (spi_dc),
        .spi_busy       (spi_busy),
        .spi_done       (spi_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI engine stand-in: busy for a few cycles after a start, then done
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (eng_cnt == 0) begin
            if (spi_start) eng_cnt <= (fix_len != 0) ? fix_len : int'($urandom_range(1, 10));
        end else if (eng_cnt == 1) begin
            eng_cnt  <= 0;
            eng_done <= 1'b1;
        end else begin
            eng_cnt <= eng_cnt - 1;
        end
    end
    assign spi_busy = (eng_cnt != 0) || hold;
    assign spi_done = eng_done || inj_done;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -100000;
    endfunction

    // Reference model: ordered queue of {delay,dc,byte}, plus the cycle the
    // sequencer is next free and the cycle the pending start pulse is due.
    logic [9:0] mq[$];
    bit         m_wait = 0;
    int         m_ready = 0;
    int         m_exp_start = -1;
    logic       m_ovf = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_dc = 1'b0;
    bit         chk_en = 0;
    int         starts[$];
    int         dones[$];
    int         sbytes[$];

    always @(negedge clk) begin : model
        int          sz;
        logic [31:0] st;
        logic [9:0]  h;
        bit          wr;
        sz = mq.size();
        if (chk_en) begin
            st = '0;
            st[0] = (sz != 0) || m_wait || (cyc < m_ready);
            st[1] = (sz == DEPTH);
            st[2] = (sz == 0);
            st[3] = m_ovf;
            st[15:8] = sz[7:0];
            check("read_value", read_value_out, (sel && addr[3:2] == 2'd3) ? st : 32'd0);
            check("ready", {31'd0, ready_out}, {31'd0, sel});
            check("spi_start", {31'd0, spi_start}, {31'd0, (m_wait && cyc == m_exp_start)});
            check("spi_data", {24'd0, spi_data_out}, {24'd0, m_data});
            check("spi_dc", {31'd0, spi_dc}, {31'd0, m_dc});
        end
        if (spi_start) begin
            starts.push_back(cyc);
            sbytes.push_back(int'(spi_data_out));
        end
        if (eng_done) dones.push_back(cyc);
        if (reset) begin
            mq.delete();
            m_wait = 0;
            m_ready = cyc + 1;
            m_exp_start = -1;
            m_ovf = 1'b0;
            m_data = '0;
            m_dc = 1'b0;
        end else begin
            if (m_wait && spi_done && cyc > m_exp_start) begin
                m_wait = 0;
                m_ready = cyc + 1;
            end
            if (!m_wait && cyc >= m_ready && sz != 0 && !spi_busy) begin
                h = mq.pop_front();
                if (!h[9]) begin
                    m_data = h[7:0];
                    m_dc = h[8];
                    m_wait = 1;
                    m_exp_start = cyc + 1;
                end else begin
                    m_ready = cyc + int'(h[7:0]) * TICK + 1;
                end
            end
            wr = sel && (wmask != 4'd0);
            if (wr && addr[3:2] != 2'd3) begin
                if (sz == DEPTH) m_ovf = 1'b1;
                else mq.push_back({addr[3:2] == 2'd2, addr[3:2] == 2'd1, wv[7:0]});
            end else if (wr && wv[3]) begin
                m_ovf = 1'b0;
            end
        end
    end

    task automatic drive(input bit s, input logic [1:0] r, input logic [3:0] m, input logic [31:0] v);
        @(posedge clk);
        #1;
        reset = 1'b0;
        inj_done = 1'b0;
        sel = s;
        addr = {28'h0, r, 2'b00};
        wmask = m;
        wv = v;
        rd = s && (m == 4'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'd0, 4'd0, 32'd0);
    endtask

    task automatic clear_logs();
        starts.delete();
        dones.delete();
        sbytes.delete();
    endtask

    initial begin
        int t0;
        int r;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1;

        // Reset state
        drive(1'b1, 2'd3, 4'd0, 32'd0);
        @(negedge clk);
        check("reset_status", read_value_out, 32'h0000_0004);
        check("reset_data", {24'd0, spi_data_out}, 32'd0);

        // Single command: start two cycles after the write
        clear_logs();
        drive(1'b1, 2'd0, 4'hF, 32'h2A);
        t0 = cyc;
        idle(20);
        check("cmd_latency", qget(starts, 0) - t0, 2);
        check("cmd_byte", qget(sbytes, 0), 32'h2A);

        // Back-to-back command + data, fixed 8-cycle engine
        fix_len = 8;
        clear_logs();
        drive(1'b1, 2'd0, 4'hF, 32'h2C);
        drive(1'b1, 2'd1, 4'hF, 32'h11);
        drive(1'b1, 2'd1, 4'hF, 32'h22);
        idle(60);
        fix_len = 0;
        check("b2b_count", starts.size(), 3);
        check("b2b_gap1", qget(starts, 1) - qget(dones, 0), 2);
        check("b2b_gap2", qget(starts, 2) - qget(dones, 1), 2);
        check("b2b_byte3", qget(sbytes, 2), 32'h22);

        // Delay of 3 ticks: 12 delay cycles + delay pop + start
        clear_logs();
        drive(1'b1, 2'd0, 4'hF, 32'h11);
        drive(1'b1, 2'd2, 4'hF, 32'h3);
        drive(1'b1, 2'd0, 4'hF, 32'h29);
        idle(60);
        check("delay3_gap", qget(starts, 1) - qget(dones, 0), 15);
        clear_logs();
        drive(1'b1, 2'd0, 4'hF, 32'h11);
        drive(1'b1, 2'd2, 4'hF, 32'h0);
        drive(1'b1, 2'd0, 4'hF, 32'h29);
        idle(40);
        check("delay0_gap", qget(starts, 1) - qget(dones, 0), 3);

        // Overflow with the engine held busy
        clear_logs();
        hold = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, 2'd1, 4'hF, 32'hA0 + i);
        drive(1'b1, 2'd3, 4'd0, 32'd0);
        @(negedge clk);
        check("ovf_status", read_value_out, 32'h0000_040B);
        drive(1'b1, 2'd3, 4'h1, 32'h8);
        drive(1'b1, 2'd3, 4'd0, 32'd0);
        @(negedge clk);
        check("ovf_cleared", read_value_out, 32'h0000_0403);
        hold = 1'b0;
        idle(100);
        check("ovf_drain_count", sbytes.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("ovf_drain_byte", qget(sbytes, i), 32'hA0 + i);

        // Reset during WAIT with entries queued
        fix_len = 8;
        clear_logs();
        for (int i = 0; i < 6; i++) drive(1'b1, 2'd0, 4'hF, 32'h50 + i);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sel = 1'b0;
        wmask = 4'd0;
        drive(1'b1, 2'd3, 4'd0, 32'd0);
        @(negedge clk);
        check("rst_status", read_value_out, 32'h0000_0004);
        check("rst_start", {31'd0, spi_start}, 32'd0);
        idle(3);
        @(posedge clk);
        #1;
        inj_done = 1'b1;
        idle(30);
        fix_len = 0;
        check("rst_no_more_starts", starts.size(), 1);

        // Bus decode: deselected and non-STATUS reads
        drive(1'b0, 2'd3, 4'd0, 32'd0);
        @(negedge clk);
        check("desel_read", read_value_out, 32'd0);
        drive(1'b1, 2'd1, 4'd0, 32'd0);
        @(negedge clk);
        check("data_read", read_value_out, 32'd0);
        check("ready_sel", {31'd0, ready_out}, 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                0, 1:    drive(1'b1, 2'd0, 4'($urandom_range(1, 15)), $urandom);
                2, 3:    drive(1'b1, 2'd1, 4'($urandom_range(1, 15)), $urandom);
                4:       drive(1'b1, 2'd2, 4'($urandom_range(1, 15)), 32'($urandom_range(0, 3)));
                5:       drive(1'b1, 2'd3, 4'($urandom_range(0, 15)), $urandom);
                6: begin
                    drive(1'b1, 2'd0, 4'd0, 32'd0);
                    addr = $urandom;
                    wmask = 4'($urandom);
                    wv = $urandom & 32'hFFFF_FF03;
                end
                default: drive(1'($urandom), 2'($urandom), 4'd0, 32'd0);
            endcase
            hold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 14) == 0) inj_done = 1'b1;
            if ($urandom_range(0, 149) == 0) reset = 1'b1;
        end
        hold = 1'b0;
        idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
